bpred_mem_bank: RTL and testbench
=================================

Name: bpred_mem_bank

Overview:
Storage bank for the perceptron branch predictor front end. It holds four independent simple-dual-port RAMs, each with one write port and one registered read port:
- Instruction memory: 256 x 32.
- Perceptron high-order-bit (HOB) weight table: 64 x 36.
- HOB complement (pre-negated) table: 64 x 36.
- Low-order-bit (LOB) weight table: 64 x 60.

Fetch logic reads the instruction memory and the three tables in parallel using the fetch PC. The execute-stage update path writes the three tables. The instruction loader writes the instruction memory.

Parameters:
- INSN_AW, 8, instruction memory address width (depth 2^INSN_AW = 256).
- INSN_W, 32, instruction word width.
- TBL_AW, 6, weight table address width (depth 64).
- GHR_SIZE, 12, number of weights per table row.
- HOB_BITS, 3, high-order bits per weight; HOB row width = HOB_BITS*GHR_SIZE = 36.
- LOB_BITS, 5, low-order bits per weight; LOB row width = LOB_BITS*GHR_SIZE = 60.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- insn_wren, input, 1, instruction memory write enable.
- insn_waddr, input, INSN_AW, instruction write address.
- insn_wdata, input, INSN_W, instruction write data.
- insn_raddr, input, INSN_AW, instruction read address (fetch PC[9:2]).
- insn_q, output, INSN_W, registered instruction read data.
- tbl_wren, input, 1, common write enable for all three weight tables.
- tbl_waddr, input, TBL_AW, common table write address (execute PC[7:2]).
- tbl_raddr, input, TBL_AW, common table read address (fetch PC[7:2]).
- hob_wdata, input, 36, HOB table write data.
- hobc_wdata, input, 36, HOB complement table write data.
- lob_wdata, input, 60, LOB table write data.
- hob_q, output, 36, registered HOB row.
- hobc_q, output, 36, registered HOB complement row.
- lob_q, output, 60, registered LOB row.

Behaviour:
- All state changes on rising edge of clk. No combinational path from any input to any output.
- Read latency is exactly 1 cycle. The address present at edge N is sampled, and the array data appears on q after edge N and is held until the next edge.
- Read every cycle. There is no read enable, and q updates on every edge.
- Write: when wren=1 at an edge, mem[waddr] <= wdata.
  - tbl_wren writes hob_wdata, hobc_wdata and lob_wdata into their three tables at tbl_waddr in the same edge.
  - The instruction port is fully independent of the table ports.
- Read-during-write to the same address on the same edge: q returns the OLD contents. The new data is visible on a read issued at the following edge.
- Writes and reads to different addresses in the same cycle do not interact.
- Reset, synchronous: when reset=1 at an edge, insn_q, hob_q, hobc_q and lob_q are forced to 0. This takes priority over the read.
- Array contents are not cleared by reset.
- Writes are still performed while reset=1. The update path relies on this to initialise table rows during reset.
- The first read after reset deasserts returns the array contents normally.
- Power-up array contents are zero, via an initial block or memory init. Power-up q registers are 0.
- Addresses are full-width binary with no out-of-range case. Predictor PC bits above the address width alias (wrap-around by truncation, done by the caller).
- Width rule: row widths are derived from the parameters. Row bit fields are opaque to this block; it does no arithmetic.
- Mappable to MLAB/M9K simple dual-port RAM with registered output. Behaviour must match the RTL model above exactly, including the old-data read-during-write rule.

Test Plan:
1. Instruction write then read:
   - Stimulus: insn_wren=1, insn_waddr=8'h05, insn_wdata=32'hDEADBEEF; next cycle insn_raddr=8'h05.
   - Response: insn_q=32'hDEADBEEF one cycle after the read address is applied; insn_q=0 for unwritten address 8'h06.
2. Table triple write:
   - Stimulus: tbl_wren=1, tbl_waddr=6'd10, hob_wdata=36'h9_2492_4924, hobc_wdata=36'h6_DB6D_B6DB, lob_wdata=60'h0FF_FFFF_FFFF_FFFF; then tbl_raddr=10.
   - Response: all three q values match next cycle; reading tbl_raddr=11 gives all zeros.
3. Read-during-write:
   - Stimulus: row 3 holds 36'h1; at one edge write 36'h2 to row 3 while tbl_raddr=3.
   - Response: hob_q=36'h1 after that edge, then 36'h2 after the next edge with tbl_raddr still 3.
4. Reset clears outputs, not contents:
   - Stimulus: after writing 32'hA5A5A5A5 to insn addr 0 with insn_raddr=0, assert reset for 2 cycles.
   - Response: insn_q=0 during reset; after deassert insn_q=32'hA5A5A5A5 within 1 cycle.
5. Write during reset:
   - Stimulus: reset=1 with tbl_wren=1, tbl_waddr=20, lob_wdata=60'h123; deassert reset, then tbl_raddr=20.
   - Response: lob_q=60'h123.
6. Pipelined back-to-back reads:
   - Stimulus: insn_raddr sequence 0,1,2,3 on consecutive cycles, with those locations preloaded with 10,11,12,13.
   - Response: insn_q shows 10,11,12,13 on consecutive cycles, each one cycle behind its address.

Source files
------------

// File: rtl/bpred_mem_bank.sv
// bpred_mem_bank
// Storage bank for the perceptron branch predictor front end. Holds four
// simple-dual-port RAMs, each with one write port and one registered read
// port that reads every cycle:
//   - instruction memory   2^INSN_AW x INSN_W
//   - HOB weight table     2^TBL_AW  x HOB_BITS*GHR_SIZE
//   - HOB complement table 2^TBL_AW  x HOB_BITS*GHR_SIZE
//   - LOB weight table     2^TBL_AW  x LOB_BITS*GHR_SIZE
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   insn_wren/waddr/wdata          instruction loader write port
//   insn_raddr -> insn_q           fetch read port, 1-cycle latency
//   tbl_wren/waddr                 shared write enable/address for all tables
//   hob_wdata/hobc_wdata/lob_wdata per-table write data
//   tbl_raddr -> hob_q/hobc_q/lob_q shared fetch read address, 1-cycle latency
// Reset zeroes the read registers only; arrays keep their contents and writes
// still take effect while reset is high.
module bpred_mem_bank #(
  parameter int INSN_AW  = 8,
  parameter int INSN_W   = 32,
  parameter int TBL_AW   = 6,
  parameter int GHR_SIZE = 12,
  parameter int HOB_BITS = 3,
  parameter int LOB_BITS = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         insn_wren,
  input  logic [INSN_AW-1:0]           insn_waddr,
  input  logic [INSN_W-1:0]            insn_wdata,
  input  logic [INSN_AW-1:0]           insn_raddr,
  output logic [INSN_W-1:0]            insn_q,
  input  logic                         tbl_wren,
  input  logic [TBL_AW-1:0]            tbl_waddr,
  input  logic [TBL_AW-1:0]            tbl_raddr,
  input  logic [HOB_BITS*GHR_SIZE-1:0] hob_wdata,
  input  logic [HOB_BITS*GHR_SIZE-1:0] hobc_wdata,
  input  logic [LOB_BITS*GHR_SIZE-1:0] lob_wdata,
  output logic [HOB_BITS*GHR_SIZE-1:0] hob_q,
  output logic [HOB_BITS*GHR_SIZE-1:0] hobc_q,
  output logic [LOB_BITS*GHR_SIZE-1:0] lob_q
);

  localparam int HOB_W      = HOB_BITS * GHR_SIZE;
  localparam int LOB_W      = LOB_BITS * GHR_SIZE;
  localparam int INSN_DEPTH = 2 ** INSN_AW;
  localparam int TBL_DEPTH  = 2 ** TBL_AW;

  // Arrays power up zeroed through declaration initialisers, which the FPGA
  // flow turns into RAM init contents; reset never touches them.
  logic [INSN_W-1:0] insn_mem [INSN_DEPTH] = '{default: '0};
  logic [HOB_W-1:0]  hob_mem  [TBL_DEPTH]  = '{default: '0};
  logic [HOB_W-1:0]  hobc_mem [TBL_DEPTH]  = '{default: '0};
  logic [LOB_W-1:0]  lob_mem  [TBL_DEPTH]  = '{default: '0};

  // Read registers, power-up zero.
  logic [INSN_W-1:0] insn_rd = '0;
  logic [HOB_W-1:0]  hob_rd  = '0;
  logic [HOB_W-1:0]  hobc_rd = '0;
  logic [LOB_W-1:0]  lob_rd  = '0;

  // Instruction array write port; deliberately ignores reset.
  always_ff @(posedge clk) begin
    if (insn_wren) begin
      insn_mem[insn_waddr] <= insn_wdata;
    end
  end

  // Weight table write port; all three tables share enable and address, and
  // writes during reset are how the update path initialises rows.
  always_ff @(posedge clk) begin
    if (tbl_wren) begin
      hob_mem[tbl_waddr]  <= hob_wdata;
      hobc_mem[tbl_waddr] <= hobc_wdata;
      lob_mem[tbl_waddr]  <= lob_wdata;
    end
  end

  // Instruction read register. Sampling the array with a non-blocking read in
  // a separate process yields old data on a same-address read-during-write,
  // matching the M9K/MLAB old-data mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      insn_rd <= '0;
    end else begin
      insn_rd <= insn_mem[insn_raddr];
    end
  end

  // Table read registers, same old-data behaviour as the instruction port.
  always_ff @(posedge clk) begin
    if (reset) begin
      hob_rd  <= '0;
      hobc_rd <= '0;
      lob_rd  <= '0;
    end else begin
      hob_rd  <= hob_mem[tbl_raddr];
      hobc_rd <= hobc_mem[tbl_raddr];
      lob_rd  <= lob_mem[tbl_raddr];
    end
  end

  assign insn_q = insn_rd;
  assign hob_q  = hob_rd;
  assign hobc_q = hobc_rd;
  assign lob_q  = lob_rd;

endmodule

// File: tb/tb_bpred_mem_bank.sv
// Self-checking bench for bpred_mem_bank. A stimulus process drives inputs on
// the falling edge and pushes the expected outputs for the next rising edge
// into a scoreboard queue, computed from a plain array model of the bank. A
// monitor process pops and compares after every rising edge.
module tb_bpred_mem_bank;

  localparam int INSN_AW = 8;
  localparam int INSN_W  = 32;
  localparam int TBL_AW  = 6;
  localparam int HOB_W   = 36;
  localparam int LOB_W   = 60;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              insn_wren = 1'b0;
  logic [INSN_AW-1:0] insn_waddr = '0;
  logic [INSN_W-1:0]  insn_wdata = '0;
  logic [INSN_AW-1:0] insn_raddr = '0;
  logic [INSN_W-1:0]  insn_q;
  logic              tbl_wren = 1'b0;
  logic [TBL_AW-1:0]  tbl_waddr = '0;
  logic [TBL_AW-1:0]  tbl_raddr = '0;
  logic [HOB_W-1:0]   hob_wdata = '0;
  logic [HOB_W-1:0]   hobc_wdata = '0;
  logic [LOB_W-1:0]   lob_wdata = '0;
  logic [HOB_W-1:0]   hob_q;
  logic [HOB_W-1:0]   hobc_q;
  logic [LOB_W-1:0]   lob_q;

  bpred_mem_bank dut (
    .clk        (clk),
    .reset      (reset),
    .insn_wren  (insn_wren),
    .insn_waddr (insn_waddr),
    .insn_wdata (insn_wdata),
    .insn_raddr (insn_raddr),
    .insn_q     (insn_q),
    .tbl_wren   (tbl_wren),
    .tbl_waddr  (tbl_waddr),
    .tbl_raddr  (tbl_raddr),
    .hob_wdata  (hob_wdata),
    .hobc_wdata (hobc_wdata),
    .lob_wdata  (lob_wdata),
    .hob_q      (hob_q),
    .hobc_q     (hobc_q),
    .lob_q      (lob_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INSN_W-1:0] insn;
    logic [HOB_W-1:0]  hob;
    logic [HOB_W-1:0]  hobc;
    logic [LOB_W-1:0]  lob;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the four arrays as plain variables, zero at power-up.
  logic [INSN_W-1:0] m_insn [256];
  logic [HOB_W-1:0]  m_hob  [64];
  logic [HOB_W-1:0]  m_hobc [64];
  logic [LOB_W-1:0]  m_lob  [64];

  int checks = 0;
  int passed = 0;

  // One clock cycle of stimulus. The expected output after the coming rising
  // edge is the model contents before this cycle's writes (old data), or zero
  // under reset; writes are then applied to the model regardless of reset.
  task automatic drive(input logic rst,
                       input logic iw, input logic [7:0] iwa, input logic [31:0] iwd,
                       input logic [7:0] ira,
                       input logic tw, input logic [5:0] twa, input logic [5:0] tra,
                       input logic [35:0] hw, input logic [35:0] hcw,
                       input logic [59:0] lw);
    exp_t e;
    @(negedge clk);
    reset = rst; insn_wren = iw; insn_waddr = iwa; insn_wdata = iwd;
    insn_raddr = ira; tbl_wren = tw; tbl_waddr = twa; tbl_raddr = tra;
    hob_wdata = hw; hobc_wdata = hcw; lob_wdata = lw;
    if (rst) begin
      e.insn = '0; e.hob = '0; e.hobc = '0; e.lob = '0;
    end else begin
      e.insn = m_insn[ira]; e.hob = m_hob[tra]; e.hobc = m_hobc[tra]; e.lob = m_lob[tra];
    end
    exp_q.push_back(e);
    if (iw) m_insn[iwa] = iwd;
    if (tw) begin
      m_hob[twa] = hw; m_hobc[twa] = hcw; m_lob[twa] = lw;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
  endtask

  // Monitor: the bank presents new output every cycle, so compare after each
  // rising edge whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("insn_q", {32'd0, insn_q}, {32'd0, e.insn});
        check("hob_q",  {28'd0, hob_q},  {28'd0, e.hob});
        check("hobc_q", {28'd0, hobc_q}, {28'd0, e.hobc});
        check("lob_q",  {4'd0, lob_q},   {4'd0, e.lob});
      end
    end
  end

  initial begin
    logic [63:0] r1, r2, r3;
    int budget;
    for (int i = 0; i < 256; i++) m_insn[i] = '0;
    for (int i = 0; i < 64; i++) begin
      m_hob[i] = '0; m_hobc[i] = '0; m_lob[i] = '0;
    end

    // Initial reset.
    drive(1'b1, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b1, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);

    // Instruction write then read, plus an unwritten neighbour.
    drive(1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 8'h00, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b0, 1'b0, 8'h00, 32'd0, 8'h05, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b0, 1'b0, 8'h00, 32'd0, 8'h06, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);

    // Table triple write, read back, unwritten row 11.
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1, 6'd10, 6'd0,
          36'h9_2492_4924, 36'h6_DB6D_B6DB, 60'h0FF_FFFF_FFFF_FFFF);
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd10, 36'd0, 36'd0, 60'd0);
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd11, 36'd0, 36'd0, 60'd0);

    // Read-during-write on row 3: old data first, new data next edge.
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1, 6'd3, 6'd0, 36'h1, 36'h0, 60'h0);
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1, 6'd3, 6'd3, 36'h2, 36'h0, 60'h0);
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd3, 36'd0, 36'd0, 60'd0);

    // Reset clears outputs but not contents.
    drive(1'b0, 1'b1, 8'h00, 32'hA5A5A5A5, 8'h00, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b0, 1'b0, 8'h00, 32'd0, 8'h00, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b1, 1'b0, 8'h00, 32'd0, 8'h00, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b1, 1'b0, 8'h00, 32'd0, 8'h00, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    drive(1'b0, 1'b0, 8'h00, 32'd0, 8'h00, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);

    // Write during reset.
    drive(1'b1, 1'b0, 8'd0, 32'd0, 8'd0, 1'b1, 6'd20, 6'd0, 36'h0, 36'h0, 60'h123);
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd20, 36'd0, 36'd0, 60'd0);

    // Preload and pipelined back-to-back reads.
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 8'(i), 32'(10 + i), 8'd0, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b0, 8'd0, 32'd0, 8'(i), 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);

    // Randomized traffic on a narrow address window to force collisions,
    // with occasional reset pulses.
    for (int n = 0; n < 1500; n++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      r3 = {$urandom, $urandom};
      drive(($urandom_range(0, 31) == 0),
            $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), $urandom,
            8'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            r1[35:0], r2[35:0], r3[59:0]);
    end
    drive(1'b0, 1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0);

    // Let the monitor drain the scoreboard, bounded.
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
